fp32_mul_round: RTL and testbench

Normalize-and-round stage directly downstream of the single-precision multiplier datapath. Accepts the raw 48-bit significand product, the unrounded biased exponent, the result sign and a special-case code, and produces a packed IEEE-754 binary32 result with overflow/underflow/inexact flags. It is a two-stage valid/ready pipeline (normalize, then round/pack) sustaining one result per cycle under backpressure.

---
 rtl/fp32_mul_round.sv | 181 ++++++++++++++++++
 tb/tb_fp32_mul_round.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_round.sv
`default_nettype none
// ============================================================================
// Module   : fp32_mul_round
// Purpose  : Normalize and round a raw fp32 multiplier product into binary32,
//            as a two-stage valid/ready pipeline with IEEE exception flags.
// Revision : 1.0 - initial release
// ============================================================================
module fp32_mul_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic [1:0]  in_special,
  input  logic [1:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [1:0]  SP_NORMAL = 2'b00;
  localparam logic [1:0]  SP_ZERO   = 2'b01;
  localparam logic [1:0]  SP_INF    = 2'b10;
  localparam logic [1:0]  RM_RNE    = 2'b00;
  localparam logic [1:0]  RM_RTZ    = 2'b01;
  localparam logic [1:0]  RM_RDN    = 2'b10;

  logic        s1_load, s2_load;
  logic        v1_q, v2_q;

  assign s2_load   = ~v2_q | out_ready;
  assign s1_load   = ~v1_q | s2_load;
  assign in_ready  = s1_load & ~rst;
  assign out_valid = v2_q;

  // ---------------- stage 1: normalize ----------------
  logic [5:0]         lz;
  logic [47:0]        norm, den;
  logic               shift_sticky, den_lost, tiny;
  logic signed [10:0] e_in, e_norm;
  logic [10:0]        sa, e_sub;

  logic [23:0] sig_d, sig_q;
  logic        g_d, g_q, s_d, s_q, tiny_d, tiny_q, sign_q;
  logic [10:0] e_q;
  logic [1:0]  rm_q, spec_d, spec_q;

  always_comb begin
    lz = '0;
    for (int i = 0; i < 47; i++) begin
      if (in_mant[i]) lz = 6'(46 - i);
    end
    e_in         = {in_exp[9], in_exp};
    norm         = in_mant;
    shift_sticky = 1'b0;
    e_norm       = e_in;
    if (in_mant[47]) begin
      norm         = in_mant >> 1;
      shift_sticky = in_mant[0];
      e_norm       = e_in + 11'sd1;
    end else if (!in_mant[46]) begin
      norm   = in_mant << lz;
      e_norm = e_in - {5'd0, lz};
    end

    // Tiny results denormalize; very large shifts leave only sticky.
    tiny     = (e_norm <= 11'sd0);
    sa       = 11'd1 - e_norm;
    den      = norm;
    den_lost = 1'b0;
    e_sub    = e_norm;
    if (tiny) begin
      e_sub = 11'd0;
      if (sa >= 11'd48) begin
        den      = '0;
        den_lost = |norm;
      end else begin
        den      = norm >> sa;
        den_lost = |(norm << (6'd48 - sa[5:0]));
      end
    end

    sig_d  = den[46:23];
    g_d    = den[22];
    s_d    = (|den[21:0]) | den_lost | shift_sticky;
    tiny_d = tiny;
    spec_d = ((in_special == SP_NORMAL) && (in_mant == 48'd0)) ? SP_ZERO : in_special;
  end

  // ---------------- stage 2: round and pack ----------------
  logic        inc, inx, ovf, to_max;
  logic [24:0] sum;
  logic [10:0] e_rnd;
  logic [22:0] frac;
  logic [31:0] res_d, res_q;
  logic        ovf_d, ovf_q, unf_d, unf_q, inx_d, inx_q;

  always_comb begin
    case (rm_q)
      RM_RNE:  inc = g_q & (s_q | sig_q[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_q & (g_q | s_q);
      default: inc = ~sign_q & (g_q | s_q);
    endcase
    sum   = {1'b0, sig_q} + {24'd0, inc};
    e_rnd = e_q;
    frac  = sum[22:0];
    if (sum[24]) begin
      e_rnd = e_q + 11'd1;
      frac  = sum[23:1];
    end else if ((e_q == 11'd0) && sum[23]) begin
      e_rnd = 11'd1;
    end
    inx    = g_q | s_q;
    ovf    = (e_rnd >= 11'd255);
    to_max = (rm_q == RM_RTZ) || ((rm_q == RM_RDN) && !sign_q) ||
             ((rm_q == 2'b11) && sign_q);

    res_d = {sign_q, e_rnd[7:0], frac};
    ovf_d = ovf;
    inx_d = inx | ovf;
    unf_d = tiny_q & inx;
    if (ovf) res_d = to_max ? {sign_q, 8'hFE, 23'h7F_FFFF} : {sign_q, 8'hFF, 23'h0};

    if (spec_q != SP_NORMAL) begin
      ovf_d = 1'b0;
      inx_d = 1'b0;
      unf_d = 1'b0;
      if (spec_q == SP_ZERO)     res_d = {sign_q, 31'h0};
      else if (spec_q == SP_INF) res_d = {sign_q, 8'hFF, 23'h0};
      else                       res_d = QNAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
    end else begin
      if (s1_load) begin
        v1_q <= in_valid;
        if (in_valid) begin
          sig_q  <= sig_d;
          g_q    <= g_d;
          s_q    <= s_d;
          e_q    <= e_sub;
          tiny_q <= tiny_d;
          sign_q <= in_sign;
          rm_q   <= in_rm;
          spec_q <= spec_d;
        end
      end
      if (s2_load) begin
        v2_q <= v1_q;
        if (v1_q) begin
          res_q <= res_d;
          ovf_q <= ovf_d;
          unf_q <= unf_d;
          inx_q <= inx_d;
        end
      end
    end
  end

  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_inexact   = inx_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_mul_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_mul_round
// Purpose  : Directed vectors, handshake sequences and a random stream checked
//            against an exact-value rounding model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_mul_round;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_sign, out_valid, out_ready;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic [1:0]  in_special, in_rm;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_mul_round dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_special(in_special), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  // expected = {overflow, underflow, inexact, result}
  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic [1:0]  sp;
    logic [1:0]  rm;
    logic [34:0] expv;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [34:0] observed();
    return {out_overflow, out_underflow, out_inexact, out_result};
  endfunction

  // Value = mant * 2^(exp-173); round to the binary32 quantum for its binade.
  function automatic logic [34:0] ref_model(input logic sign, input logic [9:0] exp,
                                            input logic [47:0] mant, input logic [1:0] sp,
                                            input logic [1:0] rm);
    int e, p, k, qe, d, s, be;
    logic [127:0] n, r, h, m;
    logic up, inx, tiny, ovf;
    logic [31:0] res;
    if (sp == 2'b11) return {3'b000, 32'h7FC0_0000};
    if (sp == 2'b10) return {3'b000, sign, 8'hFF, 23'h0};
    if (sp == 2'b01 || mant == 48'd0) return {3'b000, sign, 31'h0};
    e = int'($signed(exp));
    p = 0;
    for (int i = 0; i < 48; i++) if (mant[i]) p = i;
    k    = p + e - 173;
    tiny = (k + 127) <= 0;
    qe   = ((k < -126) ? -126 : k) - 23;
    d    = e - 173 - qe;
    m    = 128'(mant);
    if (d >= 0) begin
      n = m << d; r = '0; h = 128'd1;
    end else begin
      s = -d;
      if (s > 100) begin
        n = '0; r = m; h = '1;
      end else begin
        n = m >> s; r = m & ((128'd1 << s) - 128'd1); h = 128'd1 << (s - 1);
      end
    end
    inx = (r != 0);
    case (rm)
      2'b00:   up = (r > h) || ((r == h) && n[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = sign && inx;
      default: up = !sign && inx;
    endcase
    n = n + 128'(up);
    if (n >= (128'd1 << 24)) begin n = n >> 1; qe++; end
    be  = (n >= (128'd1 << 23)) ? qe + 150 : 0;
    ovf = (be >= 255);
    if (ovf) begin
      inx = 1'b1;
      if (rm == 2'b01 || (rm == 2'b10 && !sign) || (rm == 2'b11 && sign))
        res = {sign, 8'hFE, 23'h7F_FFFF};
      else
        res = {sign, 8'hFF, 23'h0};
    end else begin
      res = {sign, 8'(be), n[22:0]};
    end
    return {ovf, tiny & inx, inx, res};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [23:0] a, b;
    int e;
    a = 24'($urandom); b = 24'($urandom);
    a[23] = ($urandom_range(15) != 0);
    b[23] = ($urandom_range(15) != 0);
    case ($urandom_range(3))
      0:       e = int'($urandom_range(90)) - 60;
      1:       e = int'($urandom_range(60)) + 100;
      2:       e = int'($urandom_range(40)) + 230;
      default: e = int'($urandom_range(1023)) - 512;
    endcase
    v.sign = 1'($urandom);
    v.exp  = 10'(e);
    v.mant = 48'(a) * 48'(b);
    v.sp   = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00;
    v.rm   = 2'($urandom);
    v.expv = ref_model(v.sign, v.exp, v.mant, v.sp, v.rm);
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic valid);
    in_valid = valid; in_sign = v.sign; in_exp = v.exp;
    in_mant = v.mant; in_special = v.sp; in_rm = v.rm;
  endtask

  // One isolated transaction through an idle pipe with out_ready high.
  task automatic single(input vec_t v, input string name, input bit chk_lat);
    int lat;
    @(posedge clk); #1;
    drive(v, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check(name, 64'(observed()), 64'(v.expv));
    if (chk_lat) check("latency", 64'(lat), 64'd2);
  endtask

  // Streams n random vectors; optional random gaps on both handshakes.
  task automatic run_stream(input int n, input bit rnd_ready, input bit rnd_valid,
                            output int cycles);
    logic [34:0] sb[$];
    vec_t cur;
    int sent = 0, got = 0, cyc = 0;
    cur = rand_vec();
    while (got < n && cyc < n * 10 + 20) begin
      @(posedge clk); #1;
      drive(cur, (sent < n) && (!rnd_valid || $urandom_range(3) != 0));
      out_ready = rnd_ready ? 1'($urandom) : 1'b1;
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("stream_unexpected", 64'(observed()), 64'hDEAD);
        else check("stream", 64'(observed()), 64'(sb.pop_front()));
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur.expv);
        sent++;
        cur = rand_vec();
      end
    end
    check("stream_count", 64'(got), 64'(n));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cycles = cyc;
  endtask

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, got, cyc;
    logic [34:0] snap;
    vec_t none;

    tbl[0]  = '{1'b0, 10'd127, 48'h9000_0000_0000, 2'b00, 2'b00, {3'b000, 32'h4010_0000}};
    tbl[1]  = '{1'b0, 10'd127, 48'h4000_0040_0000, 2'b00, 2'b00, {3'b001, 32'h3F80_0000}};
    tbl[2]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00, 2'b00, {3'b001, 32'h3F80_0002}};
    tbl[3]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00, 2'b01, {3'b001, 32'h3F80_0001}};
    tbl[4]  = '{1'b0, 10'd254, 48'h8000_0000_0000, 2'b00, 2'b00, {3'b101, 32'h7F80_0000}};
    tbl[5]  = '{1'b0, 10'd254, 48'h8000_0000_0000, 2'b00, 2'b01, {3'b101, 32'h7F7F_FFFF}};
    tbl[6]  = '{1'b1, 10'd254, 48'h8000_0000_0000, 2'b00, 2'b11, {3'b101, 32'hFF7F_FFFF}};
    tbl[7]  = '{1'b0, 10'h3FF, 48'h4000_0000_0000, 2'b00, 2'b00, {3'b000, 32'h0020_0000}};
    tbl[8]  = '{1'b0, 10'd150, 48'h0000_0080_0000, 2'b00, 2'b00, {3'b000, 32'h3F80_0000}};
    tbl[9]  = '{1'b0, 10'd127, 48'h9000_0000_0000, 2'b11, 2'b00, {3'b000, 32'h7FC0_0000}};
    tbl[10] = '{1'b1, 10'd127, 48'h9000_0000_0000, 2'b10, 2'b00, {3'b000, 32'hFF80_0000}};
    tbl[11] = '{1'b0, 10'd127, 48'h9000_0000_0000, 2'b01, 2'b00, {3'b000, 32'h0000_0000}};
    tbl[12] = '{1'b0, 10'h3FF, 48'h4000_0000_0001, 2'b00, 2'b11, {3'b011, 32'h0020_0001}};
    tbl[13] = '{1'b0, 10'd0,   48'h7FFF_FF80_0000, 2'b00, 2'b00, {3'b011, 32'h0080_0000}};
    tbl[14] = '{1'b1, 10'd126, 48'h7FFF_FFC0_0000, 2'b00, 2'b00, {3'b001, 32'hBF80_0000}};
    none    = '{1'b0, 10'd0, 48'd0, 2'b00, 2'b00, 35'd0};

    rst = 1'b1; out_ready = 1'b1;
    drive(none, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", 64'({out_valid, observed()}), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 15; i++) single(tbl[i], $sformatf("vec%0d", i), i == 0);
    single('{1'b1, 10'd50, 48'd0, 2'b00, 2'b00, {3'b000, 32'h8000_0000}}, "exact_zero", 1'b0);

    // Backpressure: out_ready low, offer four back-to-back operands.
    @(posedge clk); #1;
    out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(tbl[idx], 1'b1);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted", 64'(idx), 64'd2);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    snap = observed();
    repeat (3) @(posedge clk);
    #1;
    check("bp_stable", 64'({out_valid, observed()}), 64'({1'b1, snap}));
    check("bp_stable_first", 64'(snap), 64'(tbl[0].expv));
    out_ready = 1'b1; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      drive(tbl[(idx < 4) ? idx : 3], idx < 4);
      @(negedge clk);
      if (out_valid && out_ready) begin
        check($sformatf("bp_order%0d", got), 64'(observed()), 64'(tbl[got].expv));
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    check("bp_count", 64'(got), 64'd4);
    in_valid = 1'b0;

    // Reset with the pipe full.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(tbl[c], 1'b1);
      @(posedge clk); #1;
    end
    check("full_before_reset", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("ready_during_reset", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("reset_flush", 64'({out_valid, observed()}), 64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("after_reset", 64'({in_ready, out_valid}), 64'b10);

    run_stream(50, 1'b0, 1'b0, cyc);
    check("throughput", 64'(cyc <= 53), 64'd1);
    run_stream(400, 1'b1, 1'b1, cyc);
    run_stream(400, 1'b0, 1'b1, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
